// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word access, big-endian byte array,
// alignment faults and a req/ready/done handshake with optional wait states.
`timescale 1ns/1ps
module data_mem_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              in_fault;
    logic              use_in;
    logic              exec;

    logic              c_we;
    logic [1:0]        c_size;
    logic              c_sext;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;

    logic [ADDR_W-1:0] a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [DATA_W-1:0] load_val;

    logic [7:0]        mem [2**ADDR_W];

    assign ready  = (state_q != WAIT);
    assign done   = (state_q == RESP);
    assign rdata  = rdata_q;
    assign fault  = fault_q;
    assign accept = req && ready;

    assign in_fault = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00));

    // Zero-wait accesses run straight from the bus; delayed ones from the latch.
    assign use_in  = (state_q != WAIT);
    assign c_we    = use_in ? we       : we_q;
    assign c_size  = use_in ? size     : size_q;
    assign c_sext  = use_in ? sign_ext : sext_q;
    assign c_addr  = use_in ? addr     : addr_q;
    assign c_wdata = use_in ? wdata    : wdata_q;

    // Gated by rst so a reset edge can never commit a write.
    assign exec = rst && (
        (accept && !in_fault && (WAIT_CYCLES == 0)) ||
        ((state_q == WAIT) && (cnt_q == 4'd0)));

    assign a1 = c_addr + ADDR_W'(1);
    assign a2 = c_addr + ADDR_W'(2);
    assign a3 = c_addr + ADDR_W'(3);

    // Assemble big-endian load data and extend it to the bus width.
    always_comb begin
        b0       = mem[c_addr];
        b1       = mem[a1];
        b2       = mem[a2];
        b3       = mem[a3];
        load_val = '0;
        if (!c_we) begin
            unique case (c_size)
                2'b00:   load_val = {{24{c_sext & b0[7]}}, b0};
                2'b01:   load_val = {{16{c_sext & b0[7]}}, b0, b1};
                2'b10:   load_val = {b0, b1, b2, b3};
                default: load_val = '0;
            endcase
        end
    end

    // Next-state and response-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (in_fault) begin
                        state_d = RESP;
                        rdata_d = '0;
                        fault_d = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        rdata_d = load_val;
                        fault_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (state_q == RESP) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdata_d = load_val;
                    fault_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Capture the request so the bus may change during wait states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Byte-lane writes into the storage array (contents survive reset).
    always_ff @(posedge clk) begin
        if (exec && c_we) begin
            unique case (c_size)
                2'b00: mem[c_addr] <= c_wdata[7:0];
                2'b01: begin
                    mem[c_addr] <= c_wdata[15:8];
                    mem[a1]     <= c_wdata[7:0];
                end
                2'b10: begin
                    mem[c_addr] <= c_wdata[31:24];
                    mem[a1]     <= c_wdata[23:16];
                    mem[a2]     <= c_wdata[15:8];
                    mem[a3]     <= c_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one zero-wait instance and one
// three-wait-state instance driven through linear step sequences.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        rst0, req0, we0, sx0;
    logic [1:0]  size0;
    logic [17:0] addr0;
    logic [31:0] wdata0, rdata0;
    logic        ready0, done0, fault0;

    logic        rst3, req3, we3, sx3;
    logic [1:0]  size3;
    logic [11:0] addr3;
    logic [31:0] wdata3, rdata3;
    logic        ready3, done3, fault3;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(18), .DATA_W(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst0), .req(req0), .we(we0), .size(size0),
        .sign_ext(sx0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .done(done0), .rdata(rdata0), .fault(fault0)
    );

    data_mem_ctrl #(.ADDR_W(12), .DATA_W(32), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we3), .size(size3),
        .sign_ext(sx3), .addr(addr3), .wdata(wdata3),
        .ready(ready3), .done(done3), .rdata(rdata3), .fault(fault3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do0(input string t, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [17:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ef);
        @(negedge clk);
        req0 = 1'b1; we0 = w; size0 = sz; sx0 = sx;
        addr0 = a; wdata0 = wd;
        chk({t, ".rdy"}, 32'(ready0), 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        chk({t, ".done"}, 32'(done0), 32'd1);
        chk({t, ".rdata"}, rdata0, er);
        chk({t, ".fault"}, 32'(fault0), 32'(ef));
    endtask

    task automatic do3(input string t, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [11:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ef, input int lat);
        @(negedge clk);
        req3 = 1'b1; we3 = w; size3 = sz; sx3 = sx;
        addr3 = a; wdata3 = wd;
        chk({t, ".rdy"}, 32'(ready3), 32'd1);
        @(posedge clk);
        #1 req3 = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({t, ".wrdy"}, 32'(ready3), 32'd0);
            chk({t, ".wdone"}, 32'(done3), 32'd0);
        end
        @(negedge clk);
        chk({t, ".done"}, 32'(done3), 32'd1);
        chk({t, ".rdata"}, rdata3, er);
        chk({t, ".fault"}, 32'(fault3), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b0; req0 = 1'b0; we0 = 1'b0; sx0 = 1'b0;
        size0 = 2'b00; addr0 = '0; wdata0 = '0;
        rst3 = 1'b0; req3 = 1'b0; we3 = 1'b0; sx3 = 1'b0;
        size3 = 2'b00; addr3 = '0; wdata3 = '0;
        #1;
        chk("rst0.ready", 32'(ready0), 32'd1);
        chk("rst0.done", 32'(done0), 32'd0);
        chk("rst0.fault", 32'(fault0), 32'd0);
        chk("rst0.rdata", rdata0, 32'd0);
        chk("rst3.ready", 32'(ready3), 32'd1);
        chk("rst3.done", 32'(done3), 32'd0);
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        rst3 = 1'b1;

        do0("sw100", 1, 2'b10, 0, 18'h100, 32'hDEADBEEF, 32'h0, 0);
        @(negedge clk);
        chk("idle.done", 32'(done0), 32'd0);
        chk("idle.ready", 32'(ready0), 32'd1);
        do0("lbu100", 0, 2'b00, 0, 18'h100, 0, 32'h000000DE, 0);
        do0("lw100", 0, 2'b10, 0, 18'h100, 0, 32'hDEADBEEF, 0);
        do0("lhu100", 0, 2'b01, 0, 18'h100, 0, 32'h0000DEAD, 0);
        do0("sb103", 1, 2'b00, 0, 18'h103, 32'h00000080, 32'h0, 0);
        do0("lw100b", 0, 2'b10, 0, 18'h100, 0, 32'hDEADBE80, 0);
        do0("lb103", 0, 2'b00, 1, 18'h103, 0, 32'hFFFFFF80, 0);
        do0("lbu103", 0, 2'b00, 0, 18'h103, 0, 32'h00000080, 0);
        do0("lh102", 0, 2'b01, 1, 18'h102, 0, 32'hFFFFBE80, 0);
        do0("swmis", 1, 2'b10, 0, 18'h101, 32'h12345678, 32'h0, 1);
        do0("lw100c", 0, 2'b10, 0, 18'h100, 0, 32'hDEADBE80, 0);
        do0("lhmis", 0, 2'b01, 1, 18'h101, 0, 32'h0, 1);
        do0("sz11", 0, 2'b11, 0, 18'h100, 0, 32'h0, 1);
        do0("sw0", 1, 2'b10, 0, 18'h0, 32'h01020304, 32'h0, 0);
        do0("swtop", 1, 2'b10, 0, 18'h3FFFC, 32'hA5A5A5A5, 32'h0, 0);
        do0("lwtop", 0, 2'b10, 0, 18'h3FFFC, 0, 32'hA5A5A5A5, 0);
        do0("lw0", 0, 2'b10, 0, 18'h0, 0, 32'h01020304, 0);

        do3("sw40", 1, 2'b10, 0, 12'h040, 32'h11223344, 32'h0, 0, 4);
        do3("sw44", 1, 2'b10, 0, 12'h044, 32'h55667788, 32'h0, 0, 4);
        do3("lw40", 0, 2'b10, 0, 12'h040, 0, 32'h11223344, 0, 4);
        do3("swmis3", 1, 2'b10, 0, 12'h041, 32'hFFFFFFFF, 32'h0, 1, 1);
        do3("lw40b", 0, 2'b10, 0, 12'h040, 0, 32'h11223344, 0, 4);

        @(negedge clk);
        req3 = 1'b1; we3 = 1'b0; size3 = 2'b10; sx3 = 1'b0;
        addr3 = 12'h040;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("b2b.done", 32'(done3), 32'((c == 4) || (c == 8)));
            chk("b2b.ready", 32'(ready3), 32'((c == 4) || (c == 8)));
            if (c == 2) addr3 = 12'h044;
            if (c == 4) chk("b2b.rd1", rdata3, 32'h11223344);
            if (c == 8) begin
                chk("b2b.rd2", rdata3, 32'h55667788);
                req3 = 1'b0;
            end
        end

        do3("sw200", 1, 2'b10, 0, 12'h200, 32'h01234567, 32'h0, 0, 4);
        do3("lw200", 0, 2'b10, 0, 12'h200, 0, 32'h01234567, 0, 4);
        @(negedge clk);
        req3 = 1'b1; we3 = 1'b1; size3 = 2'b10;
        addr3 = 12'h200; wdata3 = 32'hCAFEF00D;
        @(posedge clk);
        #1 req3 = 1'b0;
        @(negedge clk);
        chk("mid.wait", 32'(ready3), 32'd0);
        chk("mid.hold", rdata3, 32'h01234567);
        rst3 = 1'b0;
        #1;
        chk("mid.ready", 32'(ready3), 32'd1);
        chk("mid.done", 32'(done3), 32'd0);
        chk("mid.rdata", rdata3, 32'h0);
        chk("mid.fault", 32'(fault3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid.nodone", 32'(done3), 32'd0);
        end
        rst3 = 1'b1;
        do3("lw200b", 0, 2'b10, 0, 12'h200, 0, 32'h01234567, 0, 4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle byte-array data memory.
- Adds byte, halfword and word accesses with sign/zero extension, alignment-fault detection, and a req/ready/done handshake with configurable wait states, so the CPU memory stage can be exercised against slower memory.
- Sits between the CPU MEM stage and the byte-organised storage array.
- Storage is big-endian: the byte at the lowest address is the most significant.

Parameters:
- ADDR_W, 18, byte-address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 32, data bus width; fixed at 32, other values unsupported.
- WAIT_CYCLES, 0, extra cycles between request acceptance and access execution (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as fault).
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  out  1  controller can accept req this cycle.
- done  out  1  one-cycle pulse: access complete.
- rdata  out  32  load result; valid while done = 1.
- fault  out  1  valid with done: misaligned or reserved size; access suppressed.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, ready = 1, done = 0, fault = 0, rdata = 0, wait counter = 0.
  - Array contents are NOT cleared; reset mid-access aborts it with no write.
- States: IDLE, WAIT, RESP.
- Acceptance: req && ready at a rising edge latches we, size, sign_ext, addr and wdata. Inputs are ignored afterwards until the next acceptance.
- Alignment: a fault occurs when size = 01 with addr[0] = 1, when size = 10 with addr[1:0] != 0, or when size = 11.
- Faulted access:
  - Goes directly to RESP on the acceptance edge, regardless of WAIT_CYCLES.
  - done = 1, fault = 1, rdata = 0.
  - The array is not modified.
- Good access, WAIT_CYCLES = 0:
  - Executes on the acceptance edge.
  - Next state is RESP, and done is high in the following cycle.
- Good access, WAIT_CYCLES = N > 0:
  - Goes to WAIT with counter = N - 1.
  - Each WAIT edge decrements the counter.
  - The edge at which the counter = 0 executes the access and moves to RESP.
  - Latency from acceptance edge to the done cycle is N + 1 cycles.
- ready = 1 in IDLE and RESP, 0 in WAIT. A req held in RESP is accepted back-to-back.
- RESP with no req returns to IDLE. RESP with an accepted req behaves exactly as acceptance from IDLE.
- done = 1 for exactly the one cycle spent in RESP; rdata and fault are registered and held until the next RESP.
- Store byte lanes:
  - Byte store: mem[a] = wdata[7:0].
  - Halfword store: mem[a] = wdata[15:8], mem[a+1] = wdata[7:0].
  - Word store: mem[a..a+3] = wdata[31:24], [23:16], [15:8], [7:0].
  - Other bytes are untouched.
- Loads: bytes are assembled big-endian as above, right-justified, then extended to 32 bits per sign_ext.
- Stores return rdata = 0.
- Addresses index modulo 2**ADDR_W. Aligned accesses never cross the top of memory.

Test Plan:
- Word store then load, WAIT_CYCLES = 0: store word 0xDEADBEEF at addr 0x100 → done in the cycle after acceptance, fault = 0. Byte load at 0x100, sign_ext = 0 → rdata 0x000000DE. Word load at 0x100 → rdata 0xDEADBEEF.
- Sub-word store and sign extension: store byte 0x80 at 0x103 over 0xDEADBEEF → word load reads 0xDEADBE80. Byte load at 0x103 → 0xFFFFFF80 with sign_ext = 1, 0x00000080 with sign_ext = 0. Halfword load at 0x102, sign_ext = 1 → 0xFFFFBE80.
- Misalignment: word store 0x12345678 at 0x101 → done after 1 cycle, fault = 1, rdata 0. A word load at 0x100 still returns 0xDEADBE80. Halfword at 0x101 and size = 11 also fault.
- Wait states, WAIT_CYCLES = 3: req accepted → ready = 0 for 3 cycles, done on the 4th cycle after acceptance. A req held high is accepted in the RESP cycle, giving back-to-back done pulses spaced 4 cycles apart.
- Reset mid-access, WAIT_CYCLES = 3: word store 0xCAFEF00D to 0x200, with rst asserted during WAIT → outputs reset immediately, done never pulses. After release, word load at 0x200 returns its prior contents.
- Top-of-memory boundary: word store 0xA5A5A5A5 at 2**ADDR_W - 4 and word load back → rdata 0xA5A5A5A5, fault = 0, address 0 unchanged.
